// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS-I Harvard core: primary opcodes, SPECIAL
// funct codes, REGIMM rt codes, ALU operation and write-back select enums,
// the reset vector and a bus/architectural byte-order swap helper.
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // SPECIAL funct codes (instr[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // REGIMM rt codes (instr[20:16])
    localparam logic [4:0] RT_BLTZ   = 5'h00;
    localparam logic [4:0] RT_BGEZ   = 5'h01;
    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;

    // Link register index for JAL / BLTZAL / BGEZAL
    localparam logic [4:0] REG_RA = 5'd31;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_LUI
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_MEM,
        WB_LINK
    } wb_sel_e;

    // The bus places the lowest-addressed byte in bits [7:0]; architectural
    // values are big-endian, so every word crossing the bus is byte-reversed.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// -----------------------------------------------------------------------------
// mips_regfile
// 32 x 32-bit general purpose register file.
//   clk_i      : write clock (rising edge)
//   rst_ni     : asynchronous active-low clear of all registers
//   we_i       : write enable (already qualified by the core)
//   waddr_i    : write register index; index 0 is discarded
//   wdata_i    : write data
//   raddr_a_i / rdata_a_o : asynchronous read port A ($0 reads 0)
//   raddr_b_i / rdata_b_o : asynchronous read port B ($0 reads 0)
//   v0_o       : live contents of register 2
// -----------------------------------------------------------------------------
module mips_regfile (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_a_i,
    output logic [31:0] rdata_a_o,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_b_o,
    output logic [31:0] v0_o
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == 5'd0) ? 32'd0 : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == 5'd0) ? 32'd0 : regs_q[raddr_b_i];
    assign v0_o      = regs_q[2];

endmodule

// File: rtl/mips_harvard_core.sv
// -----------------------------------------------------------------------------
// mips_harvard_core
// Single-cycle MIPS-I integer subset CPU with separate instruction and data
// ports. Decode, register read, ALU and data read are combinational; PC,
// register file and store commit on the rising clock edge.
//   clk            : clock
//   reset          : asynchronous active-low reset
//   clk_enable     : 0 freezes all architectural state
//   active         : 1 while running, 0 once halted (jump/branch to 0)
//   register_v0    : live value of GPR 2
//   instr_address  : current PC
//   instr_readdata : instruction word, bus byte order
//   data_address   : load/store address (ALU result)
//   data_write     : store strobe, memory samples it on rising clk
//   data_read      : load strobe
//   data_writedata : store data, bus byte order
//   data_readdata  : load data, bus byte order
// -----------------------------------------------------------------------------
module mips_harvard_core
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    output logic        active,
    output logic [31:0] register_v0,
    output logic [31:0] instr_address,
    input  logic [31:0] instr_readdata,
    output logic [31:0] data_address,
    output logic        data_write,
    output logic        data_read,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata
);

    // Program counter and delay-slot state
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;
    logic        pend_q, pend_d;
    logic        active_q, active_d;
    logic        commit;

    // Instruction fields
    logic [31:0] instr;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs_f, rt_f, rd_f, shamt_f;
    logic [15:0] imm_f;
    logic [25:0] jidx_f;

    logic [31:0] imm_sext, imm_zext;
    logic [31:0] pc_plus4, pc_plus8, br_rel, j_abs;
    logic [31:0] rs_val, rt_val;

    // Decoder outputs
    alu_op_e     alu_op;
    wb_sel_e     wb_sel;
    logic        use_imm, zext_imm, shift_var;
    logic        reg_we, is_lw, is_sw, br_taken;
    logic [4:0]  waddr;
    logic [31:0] br_target;

    // Datapath
    logic [31:0] alu_b, alu_res, wb_data;
    logic [4:0]  sh_amt;

    assign instr   = bswap32(instr_readdata);
    assign opcode  = instr[31:26];
    assign rs_f    = instr[25:21];
    assign rt_f    = instr[20:16];
    assign rd_f    = instr[15:11];
    assign shamt_f = instr[10:6];
    assign funct   = instr[5:0];
    assign imm_f   = instr[15:0];
    assign jidx_f  = instr[25:0];

    assign imm_sext = {{16{imm_f[15]}}, imm_f};
    assign imm_zext = {16'd0, imm_f};
    assign pc_plus4 = pc_q + 32'd4;
    assign pc_plus8 = pc_q + 32'd8;
    assign br_rel   = pc_plus4 + {imm_sext[29:0], 2'b00};
    assign j_abs    = {pc_plus4[31:28], jidx_f, 2'b00};

    mips_regfile u_regfile (
        .clk_i     (clk),
        .rst_ni    (reset),
        .we_i      (reg_we && commit),
        .waddr_i   (waddr),
        .wdata_i   (wb_data),
        .raddr_a_i (rs_f),
        .rdata_a_o (rs_val),
        .raddr_b_i (rt_f),
        .rdata_b_o (rt_val),
        .v0_o      (register_v0)
    );

    // Decoder: unsupported encodings fall through the defaults and act as NOP.
    always_comb begin
        alu_op    = ALU_ADD;
        wb_sel    = WB_ALU;
        use_imm   = 1'b0;
        zext_imm  = 1'b0;
        shift_var = 1'b0;
        reg_we    = 1'b0;
        is_lw     = 1'b0;
        is_sw     = 1'b0;
        br_taken  = 1'b0;
        waddr     = 5'd0;
        br_target = br_rel;

        case (opcode)
            OP_SPECIAL: begin
                waddr = rd_f;
                case (funct)
                    FN_SLL:  begin alu_op = ALU_SLL; reg_we = 1'b1; end
                    FN_SRL:  begin alu_op = ALU_SRL; reg_we = 1'b1; end
                    FN_SRA:  begin alu_op = ALU_SRA; reg_we = 1'b1; end
                    FN_SLLV: begin alu_op = ALU_SLL; shift_var = 1'b1; reg_we = 1'b1; end
                    FN_SRLV: begin alu_op = ALU_SRL; shift_var = 1'b1; reg_we = 1'b1; end
                    FN_SRAV: begin alu_op = ALU_SRA; shift_var = 1'b1; reg_we = 1'b1; end
                    FN_JR: begin
                        br_taken  = 1'b1;
                        br_target = rs_val;
                    end
                    FN_JALR: begin
                        br_taken  = 1'b1;
                        br_target = rs_val;
                        reg_we    = 1'b1;
                        wb_sel    = WB_LINK;
                    end
                    FN_ADDU: begin alu_op = ALU_ADD;  reg_we = 1'b1; end
                    FN_SUBU: begin alu_op = ALU_SUB;  reg_we = 1'b1; end
                    FN_AND:  begin alu_op = ALU_AND;  reg_we = 1'b1; end
                    FN_OR:   begin alu_op = ALU_OR;   reg_we = 1'b1; end
                    FN_XOR:  begin alu_op = ALU_XOR;  reg_we = 1'b1; end
                    FN_SLT:  begin alu_op = ALU_SLT;  reg_we = 1'b1; end
                    FN_SLTU: begin alu_op = ALU_SLTU; reg_we = 1'b1; end
                    default: ;
                endcase
            end
            OP_REGIMM: begin
                case (rt_f)
                    RT_BLTZ: br_taken = rs_val[31];
                    RT_BGEZ: br_taken = !rs_val[31];
                    // The -AL forms link whether or not the branch is taken.
                    RT_BLTZAL: begin
                        br_taken = rs_val[31];
                        reg_we   = 1'b1;
                        waddr    = REG_RA;
                        wb_sel   = WB_LINK;
                    end
                    RT_BGEZAL: begin
                        br_taken = !rs_val[31];
                        reg_we   = 1'b1;
                        waddr    = REG_RA;
                        wb_sel   = WB_LINK;
                    end
                    default: ;
                endcase
            end
            OP_J: begin
                br_taken  = 1'b1;
                br_target = j_abs;
            end
            OP_JAL: begin
                br_taken  = 1'b1;
                br_target = j_abs;
                reg_we    = 1'b1;
                waddr     = REG_RA;
                wb_sel    = WB_LINK;
            end
            OP_BEQ:  br_taken = (rs_val == rt_val);
            OP_BNE:  br_taken = (rs_val != rt_val);
            OP_BLEZ: br_taken = rs_val[31] || (rs_val == 32'd0);
            OP_BGTZ: br_taken = !rs_val[31] && (rs_val != 32'd0);
            OP_ADDIU: begin alu_op = ALU_ADD;  use_imm = 1'b1; reg_we = 1'b1; waddr = rt_f; end
            OP_SLTI:  begin alu_op = ALU_SLT;  use_imm = 1'b1; reg_we = 1'b1; waddr = rt_f; end
            OP_SLTIU: begin alu_op = ALU_SLTU; use_imm = 1'b1; reg_we = 1'b1; waddr = rt_f; end
            OP_ANDI: begin
                alu_op = ALU_AND; use_imm = 1'b1; zext_imm = 1'b1; reg_we = 1'b1; waddr = rt_f;
            end
            OP_ORI: begin
                alu_op = ALU_OR;  use_imm = 1'b1; zext_imm = 1'b1; reg_we = 1'b1; waddr = rt_f;
            end
            OP_XORI: begin
                alu_op = ALU_XOR; use_imm = 1'b1; zext_imm = 1'b1; reg_we = 1'b1; waddr = rt_f;
            end
            OP_LUI: begin alu_op = ALU_LUI; reg_we = 1'b1; waddr = rt_f; end
            OP_LW: begin
                use_imm = 1'b1;
                is_lw   = 1'b1;
                reg_we  = 1'b1;
                waddr   = rt_f;
                wb_sel  = WB_MEM;
            end
            OP_SW: begin
                use_imm = 1'b1;
                is_sw   = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU: operand A is always rs; shifts operate on rt (carried in alu_b).
    assign alu_b  = use_imm ? (zext_imm ? imm_zext : imm_sext) : rt_val;
    assign sh_amt = shift_var ? rs_val[4:0] : shamt_f;

    always_comb begin
        alu_res = 32'd0;
        case (alu_op)
            ALU_ADD:  alu_res = rs_val + alu_b;
            ALU_SUB:  alu_res = rs_val - alu_b;
            ALU_AND:  alu_res = rs_val & alu_b;
            ALU_OR:   alu_res = rs_val | alu_b;
            ALU_XOR:  alu_res = rs_val ^ alu_b;
            ALU_SLT:  alu_res = {31'd0, $signed(rs_val) < $signed(alu_b)};
            ALU_SLTU: alu_res = {31'd0, rs_val < alu_b};
            ALU_SLL:  alu_res = alu_b << sh_amt;
            ALU_SRL:  alu_res = alu_b >> sh_amt;
            ALU_SRA:  alu_res = $unsigned($signed(alu_b) >>> sh_amt);
            ALU_LUI:  alu_res = {imm_f, 16'd0};
            default:  alu_res = 32'd0;
        endcase
    end

    always_comb begin
        wb_data = alu_res;
        case (wb_sel)
            WB_MEM:  wb_data = bswap32(data_readdata);
            WB_LINK: wb_data = pc_plus8;
            default: wb_data = alu_res;
        endcase
    end

    // PC sequencing: a taken branch arms target_q; the following (delay-slot)
    // instruction completes and only then does the PC load the target. A
    // target of zero means halt once the delay slot retires.
    assign commit   = clk_enable && active_q;
    assign pc_d     = pend_q ? target_q : pc_plus4;
    assign pend_d   = br_taken;
    assign target_d = br_target;
    assign active_d = !(pend_q && (target_q == 32'd0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_VECTOR;
            target_q <= 32'd0;
            pend_q   <= 1'b0;
            active_q <= 1'b1;
        end else if (commit) begin
            pc_q     <= pc_d;
            target_q <= target_d;
            pend_q   <= pend_d;
            active_q <= active_d;
        end
    end

    assign active         = active_q;
    assign instr_address  = pc_q;
    assign data_address   = alu_res;
    assign data_writedata = bswap32(rt_val);
    // Strobes are forced low while halted or in reset; the store strobe also
    // drops with clk_enable so a frozen core never writes memory.
    assign data_read      = is_lw && active_q && reset;
    assign data_write     = is_sw && commit && reset;

endmodule

// File: tb/tb_mips_harvard_core.sv
// -----------------------------------------------------------------------------
// tb_mips_harvard_core
// Directed programs for mips_harvard_core. Instruction ROM and data RAM are
// modelled here; every store seen on the bus is popped against an expected
// queue filled when each program is loaded.
// -----------------------------------------------------------------------------
module tb_mips_harvard_core;

    localparam logic [31:0] BASE = 32'hBFC0_0000;

    localparam logic [5:0] REGIMM = 6'h01, JAL = 6'h03, BEQ = 6'h04, BNE = 6'h05;
    localparam logic [5:0] BLEZ = 6'h06, BGTZ = 6'h07, ADDIU = 6'h09, SLTI = 6'h0A;
    localparam logic [5:0] SLTIU = 6'h0B, ANDI = 6'h0C, ORI = 6'h0D, XORI = 6'h0E;
    localparam logic [5:0] LUI = 6'h0F, LW = 6'h23, SW = 6'h2B;
    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR = 6'h08, F_JALR = 6'h09;
    localparam logic [5:0] F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25;
    localparam logic [5:0] F_XOR = 6'h26, F_SLT = 6'h2A, F_SLTU = 6'h2B;
    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] JR0 = 32'h0000_0008;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_enable = 1'b1;
    logic        active;
    logic [31:0] register_v0, instr_address, instr_readdata;
    logic [31:0] data_address, data_writedata, data_readdata;
    logic        data_write, data_read;

    logic [31:0] rom [0:127];
    logic [31:0] dmem [0:255];
    logic [31:0] rom_off;
    logic        clr_mem = 1'b0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;
    logic [15:0] st_off;
    int          n_emit;
    int          errors = 0;
    int          checks = 0;

    mips_harvard_core dut (
        .clk            (clk),
        .reset          (reset),
        .clk_enable     (clk_enable),
        .active         (active),
        .register_v0    (register_v0),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata),
        .data_address   (data_address),
        .data_write     (data_write),
        .data_read      (data_read),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Memories
    assign rom_off        = instr_address - BASE;
    assign instr_readdata = (rom_off < 32'd512) ? swap(rom[rom_off[8:2]]) : NOP;
    assign data_readdata  = dmem[data_address[9:2]];

    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 256; i++) dmem[i] <= 32'd0;
        end else if (data_write) begin
            dmem[data_address[9:2]] <= data_writedata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Store monitor: each bus store pops the next expected {address, data}.
    always @(negedge clk) begin
        if (data_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("st_extra", data_address, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("st_addr", data_address, mon_e[63:32]);
                check("st_data", data_writedata, mon_e[31:0]);
            end
        end
    end

    // Instruction encoders
    function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    // op rt, rs, imm  (loads/stores: op rt, imm(rs))
    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // op rs, rt, offset
    function automatic logic [31:0] b_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic new_program();
        for (int i = 0; i < 128; i++) rom[i] = NOP;
        n_emit = 0;
        st_off = 16'h0200;
        exp_q.delete();
    endtask

    task automatic emit(input logic [31:0] ins);
        rom[n_emit] = ins;
        n_emit++;
    endtask

    task automatic expect_store(input logic [31:0] addr, input logic [31:0] arch);
        exp_q.push_back({addr, swap(arch)});
    endtask

    // Execute one ALU instruction writing $6, then store $6 and expect val.
    task automatic op_store(input logic [31:0] ins, input logic [31:0] val);
        emit(ins);
        emit(i_ins(SW, 5'd6, 5'd0, st_off));
        expect_store({16'd0, st_off}, val);
        st_off = st_off + 16'd4;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        clk_enable = 1'b1;
        clr_mem = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr_mem = 1'b0;
    endtask

    task automatic run_to_halt(input int budget, output int cycles);
        cycles = 0;
        while (active === 1'b1 && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("halt_reached", {31'd0, active}, 32'd0);
    endtask

    task automatic load_loop();
        new_program();
        emit(i_ins(ADDIU, 5'd10, 5'd0, 16'd20));
        emit(i_ins(ADDIU, 5'd2, 5'd0, 16'd0));
        emit(i_ins(ADDIU, 5'd2, 5'd2, 16'd1));
        emit(b_ins(BNE, 5'd2, 5'd10, 16'hFFFE));
        emit(NOP);
        emit(i_ins(SW, 5'd2, 5'd0, 16'h0110));
        emit(JR0);
        emit(NOP);
        expect_store(32'h0000_0110, 32'd20);
    endtask

    int          cyc;
    logic [31:0] ta;
    int          k;

    initial begin
        // ---- Program 1: reset state, ADDIU / JR $0 halt ----
        new_program();
        emit(i_ins(ADDIU, 5'd2, 5'd0, 16'd5));
        emit(JR0);
        emit(NOP);
        apply_reset();
        #1;
        check("rst_pc", instr_address, BASE);
        check("rst_v0", register_v0, 32'd0);
        check("rst_active", {31'd0, active}, 32'd1);
        check("rst_dwr", {31'd0, data_write}, 32'd0);
        reset = 1'b1;
        run_to_halt(50, cyc);
        check("p1_cycles", cyc, 32'd3);
        check("p1_v0", register_v0, 32'd5);
        check("p1_pc", instr_address, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("p1_hold_pc", instr_address, 32'd0);
        check("p1_hold_act", {31'd0, active}, 32'd0);
        check("p1_q", exp_q.size(), 32'd0);

        // ---- Program 2: BLTZAL link and skip ----
        new_program();
        emit(i_ins(LUI, 5'd8, 5'd0, 16'h8000));
        emit({REGIMM, 5'd8, 5'h10, 16'd2});
        emit(NOP);
        emit(i_ins(ADDIU, 5'd2, 5'd0, 16'h0077));
        emit(i_ins(SW, 5'd31, 5'd0, 16'h0104));
        emit(JR0);
        emit(NOP);
        expect_store(32'h0000_0104, 32'hBFC0_000C);
        apply_reset();
        reset = 1'b1;
        run_to_halt(50, cyc);
        check("p2_v0", register_v0, 32'd0);
        check("p2_mem", dmem[65], 32'h0C00_C0BF);
        check("p2_q", exp_q.size(), 32'd0);

        // ---- Program 3: BEQ taken with delay slot, BNE not taken ----
        new_program();
        emit(i_ins(ADDIU, 5'd2, 5'd0, 16'd10));
        emit(i_ins(ADDIU, 5'd3, 5'd0, 16'd10));
        emit(b_ins(BEQ, 5'd2, 5'd3, 16'd2));
        emit(i_ins(ADDIU, 5'd2, 5'd2, 16'd1));
        emit(i_ins(ADDIU, 5'd2, 5'd2, 16'd100));
        emit(b_ins(BNE, 5'd2, 5'd2, 16'd3));
        emit(i_ins(ADDIU, 5'd2, 5'd2, 16'd2));
        emit(i_ins(ADDIU, 5'd2, 5'd2, 16'd4));
        emit(i_ins(SW, 5'd2, 5'd0, 16'h0108));
        emit(JR0);
        emit(NOP);
        expect_store(32'h0000_0108, 32'd17);
        apply_reset();
        reset = 1'b1;
        run_to_halt(50, cyc);
        check("p3_v0", register_v0, 32'd17);
        check("p3_q", exp_q.size(), 32'd0);

        // ---- Program 4: SW / LW byte order, load strobe ----
        new_program();
        emit(i_ins(LW, 5'd2, 5'd0, 16'h0100));
        emit(i_ins(LUI, 5'd9, 5'd0, 16'h1234));
        emit(i_ins(ORI, 5'd9, 5'd9, 16'h5678));
        emit(i_ins(SW, 5'd9, 5'd0, 16'h0100));
        emit(i_ins(LW, 5'd2, 5'd0, 16'h0100));
        emit(i_ins(SW, 5'd2, 5'd0, 16'h010C));
        emit(JR0);
        emit(NOP);
        expect_store(32'h0000_0100, 32'h1234_5678);
        expect_store(32'h0000_010C, 32'h1234_5678);
        apply_reset();
        #1;
        check("rst_drd", {31'd0, data_read}, 32'd0);
        reset = 1'b1;
        #1;
        check("p4_drd", {31'd0, data_read}, 32'd1);
        check("p4_daddr", data_address, 32'h0000_0100);
        run_to_halt(50, cyc);
        check("p4_v0", register_v0, 32'h1234_5678);
        check("p4_busword", dmem[64], 32'h7856_3412);
        check("p4_q", exp_q.size(), 32'd0);

        // ---- Program 5: ALU, immediates, links, remaining branches ----
        new_program();
        emit(i_ins(LUI, 5'd4, 5'd0, 16'h8765));
        emit(i_ins(ORI, 5'd4, 5'd4, 16'h4321));
        emit(i_ins(ADDIU, 5'd5, 5'd0, 16'hFFFD));
        emit(i_ins(ADDIU, 5'd7, 5'd0, 16'd8));
        op_store(r_ins(F_ADDU, 5'd6, 5'd4, 5'd5, 5'd0), 32'h8765_431E);
        op_store(r_ins(F_SUBU, 5'd6, 5'd4, 5'd5, 5'd0), 32'h8765_4324);
        op_store(r_ins(F_AND,  5'd6, 5'd4, 5'd5, 5'd0), 32'h8765_4321);
        op_store(r_ins(F_OR,   5'd6, 5'd4, 5'd5, 5'd0), 32'hFFFF_FFFD);
        op_store(r_ins(F_XOR,  5'd6, 5'd4, 5'd5, 5'd0), 32'h789A_BCDC);
        op_store(r_ins(F_SLT,  5'd6, 5'd4, 5'd5, 5'd0), 32'd1);
        op_store(r_ins(F_SLTU, 5'd6, 5'd4, 5'd5, 5'd0), 32'd1);
        op_store(r_ins(F_SLT,  5'd6, 5'd5, 5'd7, 5'd0), 32'd1);
        op_store(r_ins(F_SLTU, 5'd6, 5'd5, 5'd7, 5'd0), 32'd0);
        op_store(r_ins(F_SLL,  5'd6, 5'd0, 5'd4, 5'd4), 32'h7654_3210);
        op_store(r_ins(F_SRL,  5'd6, 5'd0, 5'd4, 5'd4), 32'h0876_5432);
        op_store(r_ins(F_SRA,  5'd6, 5'd0, 5'd4, 5'd4), 32'hF876_5432);
        op_store(r_ins(F_SLLV, 5'd6, 5'd7, 5'd4, 5'd0), 32'h6543_2100);
        op_store(r_ins(F_SRLV, 5'd6, 5'd7, 5'd4, 5'd0), 32'h0087_6543);
        op_store(r_ins(F_SRAV, 5'd6, 5'd7, 5'd4, 5'd0), 32'hFF87_6543);
        op_store(i_ins(ANDI,  5'd6, 5'd5, 16'h8001), 32'h0000_8001);
        op_store(i_ins(ORI,   5'd6, 5'd0, 16'h8000), 32'h0000_8000);
        op_store(i_ins(XORI,  5'd6, 5'd5, 16'hFFFF), 32'hFFFF_0002);
        op_store(i_ins(ADDIU, 5'd6, 5'd4, 16'h8000), 32'h8764_C321);
        op_store(i_ins(SLTI,  5'd6, 5'd5, 16'hFFFE), 32'd1);
        op_store(i_ins(SLTIU, 5'd6, 5'd5, 16'hFFFE), 32'd1);
        op_store(i_ins(SLTIU, 5'd6, 5'd5, 16'h7FFF), 32'd0);
        op_store(i_ins(LUI,   5'd6, 5'd0, 16'hABCD), 32'hABCD_0000);
        // BGEZAL on a negative value: not taken but still links
        k = n_emit;
        emit({REGIMM, 5'd5, 5'h11, 16'd2});
        emit(NOP);
        emit(i_ins(SW, 5'd31, 5'd0, st_off));
        expect_store({16'd0, st_off}, BASE + 32'(k * 4 + 8));
        st_off = st_off + 16'd4;
        // BGEZ on a negative value: falls through into ORI
        emit(b_ins(6'h01, 5'd5, 5'd1, 16'd2));
        emit(NOP);
        op_store(i_ins(ORI, 5'd6, 5'd0, 16'h005A), 32'h0000_005A);
        // BGTZ / BLEZ taken, skipping a write of $2
        emit(b_ins(BGTZ, 5'd7, 5'd0, 16'd2));
        emit(NOP);
        emit(i_ins(ADDIU, 5'd2, 5'd0, 16'h0097));
        emit(b_ins(BLEZ, 5'd5, 5'd0, 16'd2));
        emit(NOP);
        emit(i_ins(ADDIU, 5'd2, 5'd0, 16'h0096));
        // JAL over one instruction
        k = n_emit;
        ta = BASE + 32'((k + 3) * 4);
        emit({JAL, ta[27:2]});
        emit(NOP);
        emit(i_ins(ADDIU, 5'd2, 5'd0, 16'h0099));
        emit(i_ins(SW, 5'd31, 5'd0, st_off));
        expect_store({16'd0, st_off}, BASE + 32'(k * 4 + 8));
        st_off = st_off + 16'd4;
        // JALR $11, $9 over one instruction
        k = n_emit + 2;
        emit(i_ins(LUI, 5'd9, 5'd0, 16'hBFC0));
        emit(i_ins(ORI, 5'd9, 5'd9, 16'((k + 3) * 4)));
        emit(r_ins(F_JALR, 5'd11, 5'd9, 5'd0, 5'd0));
        emit(NOP);
        emit(i_ins(ADDIU, 5'd2, 5'd0, 16'h0098));
        emit(i_ins(SW, 5'd11, 5'd0, st_off));
        expect_store({16'd0, st_off}, BASE + 32'(k * 4 + 8));
        emit(JR0);
        emit(NOP);
        apply_reset();
        reset = 1'b1;
        run_to_halt(300, cyc);
        check("p5_v0", register_v0, 32'd0);
        check("p5_q", exp_q.size(), 32'd0);

        // ---- Program 6: clk_enable stall mid-loop ----
        load_loop();
        apply_reset();
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("p6_pc_pre", instr_address, BASE + 32'h10);
        check("p6_v0_pre", register_v0, 32'd3);
        @(negedge clk);
        clk_enable = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("p6_pc_stall", instr_address, BASE + 32'h10);
        check("p6_v0_stall", register_v0, 32'd3);
        check("p6_act_stall", {31'd0, active}, 32'd1);
        @(negedge clk);
        clk_enable = 1'b1;
        run_to_halt(500, cyc);
        check("p6_v0", register_v0, 32'd20);
        check("p6_q", exp_q.size(), 32'd0);

        // ---- Program 7: asynchronous reset mid-loop ----
        load_loop();
        apply_reset();
        reset = 1'b1;
        repeat (7) @(posedge clk);
        #2;
        clk_enable = 1'b0;
        reset = 1'b0;
        #1;
        check("p7_pc", instr_address, BASE);
        check("p7_v0", register_v0, 32'd0);
        check("p7_active", {31'd0, active}, 32'd1);
        @(negedge clk);
        clk_enable = 1'b1;
        reset = 1'b1;
        run_to_halt(500, cyc);
        check("p7_v0_end", register_v0, 32'd20);
        check("p7_q", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_harvard_core.md
# mips_harvard_core

Single-cycle, 32-bit MIPS-I integer subset CPU with separate instruction and data memory ports (Harvard). It fetches from a combinational instruction ROM, accesses a data RAM with combinational reads and clocked writes, and exposes `$v0` and a run/halt flag to the surrounding system. It is the compute core for directed-program testbenches and the top of the CPU hierarchy.

## Interface
No parameters.
- `clk` input 1 – single clock, all state updates on rising edge.
- `reset` input 1 – asynchronous, active-low reset.
- `clk_enable` input 1 – when 0, no architectural state (PC, registers, memory write) changes.
- `active` output 1 – 1 while executing; 0 once halted.
- `register_v0` output 32 – live value of GPR 2.
- `instr_address` output 32 – current PC.
- `instr_readdata` input 32 – instruction word, bus byte order.
- `data_address` output 32 – word address for load/store (ALU result).
- `data_write` output 1 – store strobe, sampled on rising `clk`.
- `data_read` output 1 – load strobe, combinational read.
- `data_writedata` output 32 – store data, bus byte order.
- `data_readdata` input 32 – load data, bus byte order.

## Operation
- Bus byte order: byte at lowest address occupies bits [7:0]. Core byte-swaps `instr_readdata`, `data_readdata` and `data_writedata`, so architectural values are big-endian MIPS.
- Reset vector 0xBFC00000. Halt: a jump/branch to address 0x00000000; after its delay slot executes, PC = 0, `active` drops to 0 and stays 0 until reset.
- Supported: ADDU, SUBU, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, SLLV, SRLV, SRAV, JR, JALR, ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LUI, LW, SW, BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, BLTZAL, BGEZAL, J, JAL.
- One branch delay slot for every branch and jump. Branch target = PC+4 + (sign-extended imm << 2). J/JAL target = {(PC+4)[31:28], imm26, 2'b00}.
- Links: JAL, BLTZAL, BGEZAL write `$31` = PC+8 (BLTZAL/BGEZAL link even when not taken); JALR writes `rd` = PC+8.
- Writes to `$0` discarded; `$0` reads 0. Arithmetic wraps mod 2^32, no overflow traps. ANDI/ORI/XORI zero-extend; others sign-extend. SLTIU compares sign-extended imm unsigned.
- Unsupported opcodes execute as NOP. LW/SW addresses always word aligned by program; low 2 bits passed through unchanged.
- `data_read` = 1 only for LW, `data_write` = 1 only for SW; both 0 otherwise, when halted, and in reset.

## Timing
- Single cycle per instruction: decode, register read, ALU and data read combinational within the cycle; PC, register file and store commit on rising `clk` when `clk_enable` = 1 and `active` = 1.
- Reset asserted (low): PC = 0xBFC00000, all GPRs = 0, `register_v0` = 0, `active` = 1, delay-slot state cleared. Reset mid-program aborts immediately, regardless of `clk_enable`.
- Delay slot: registered pending-target + valid flag; instruction after the branch completes, then PC loads target.
- Branch in a delay slot: undefined, not required.
- Load result available to the next instruction (no load delay).
- `register_v0` reflects the register file contents (updates the edge after the writing instruction).

## Structure
- Package `mips_pkg`: opcode, funct and REGIMM rt codes, ALU-op enum, reset vector constant.
- Sub-module `mips_regfile`: 32×32, two async read ports, one sync write port, `$0` hardwired, async active-low clear, dedicated `$v0` tap.
- Core: PC/delay-slot logic, decoder, ALU, byte-swap, halt flag.

## Test plan
- Reset, program `ADDIU $2,$0,5; JR $0; NOP` → `register_v0` = 5, `active` falls after the delay slot, PC = 0.
- `LUI $8,0x8000; BLTZAL $8,+2; NOP; …; SW $31,0x104($0)` at 0xBFC00000 → mem[0x104] = 0xBFC0000C; the skipped instruction does not execute.
- BEQ taken with delay-slot `ADDIU $2,$2,1` → delay-slot increment visible; not-taken BNE falls through.
- `SW` 0x12345678 to 0x100 then `LW` into `$2` → `register_v0` = 0x12345678, bus word at 0x100 reads 0x78563412.
- `clk_enable` = 0 for 5 cycles mid-program → PC, `register_v0`, memory unchanged; resumes correctly.
- Assert reset mid-loop → PC returns to 0xBFC00000, `register_v0` = 0, `active` = 1.
